// File: rtl/ex_port_bank_if.sv
// rtl/ex_port_bank_if.sv - CPU bus bundle between the 6502 address decode and ex_port_bank
interface ex_port_bank_if #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 8
);
  logic [AddressWidth-1:0] bus_addr_i;
  logic [DataWidth-1:0]    bus_wdata_i;
  logic                    bus_we_i;
  logic [DataWidth-1:0]    bus_rdata_o;

  modport master (output bus_addr_i, bus_wdata_i, bus_we_i, input bus_rdata_o);
  modport slave  (input bus_addr_i, bus_wdata_i, bus_we_i, output bus_rdata_o);
endinterface

// File: rtl/ex_port_bank.sv
// rtl/ex_port_bank.sv - bus-writable output channels with STATIC/PWM/ONESHOT aux outputs
// Readback mux is present only when EX_PORT_READBACK_EN is defined; otherwise bus_rdata_o is 0.
module ex_port_bank #(
  parameter int                      NumChannels  = 4,
  parameter int                      DataWidth    = 8,
  parameter int                      AddressWidth = 16,
  parameter logic [AddressWidth-1:0] BaseAddress  = 16'h9100,
  parameter int                      PrescaleDiv  = 48
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  ex_port_bank_if.slave                    bus,
  output logic [NumChannels*DataWidth-1:0] ex_data_o,
  output logic [NumChannels-1:0]           ex_aux_o
);
  localparam int                      PW       = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam int                      CW       = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam logic [PW-1:0]           PresLast = PW'(PrescaleDiv - 1);
  localparam logic [AddressWidth-1:0] WinSize  = AddressWidth'(2 * NumChannels);
  localparam logic [1:0]              ModePwm     = 2'b01;
  localparam logic [1:0]              ModeOneshot = 2'b10;

  logic [PW-1:0]           r_presc;
  logic [DataWidth-1:0]    r_pwm_cnt;
  logic [DataWidth-1:0]    w_pwm_cnt_nxt;
  logic                    w_tick;
  logic                    w_wrap;
  logic [AddressWidth-1:0] w_off;
  logic                    w_in_win;
  logic [CW-1:0]           w_ch;
  logic                    w_sel_ctrl;
  logic [NumChannels-1:0]  w_wr_val;
  logic [NumChannels-1:0]  w_wr_ctl;
  logic [NumChannels-1:0]  w_aux_nxt;
  logic [NumChannels-1:0]  r_aux;
  logic [DataWidth-1:0]    r_value      [NumChannels];
  logic [DataWidth-1:0]    r_shadow     [NumChannels];
  logic [DataWidth-1:0]    r_pulse      [NumChannels];
  logic [DataWidth-1:0]    w_shadow_nxt [NumChannels];
  logic [DataWidth-1:0]    w_pulse_nxt  [NumChannels];
  logic [1:0]              r_mode       [NumChannels];
  logic [1:0]              w_mode_nxt   [NumChannels];

  // Unsigned wrap makes addresses below BaseAddress land far outside the window.
  assign w_off         = bus.bus_addr_i - BaseAddress;
  assign w_in_win      = (w_off < WinSize);
  assign w_ch          = w_off[CW:1];
  assign w_sel_ctrl    = w_off[0];
  assign w_tick        = (r_presc == PresLast);
  assign w_wrap        = w_tick && (r_pwm_cnt == '1);
  assign w_pwm_cnt_nxt = w_tick ? r_pwm_cnt + DataWidth'(1) : r_pwm_cnt;

  // aux is registered from next-state values so it tracks counters and mode on the same edge.
  always_comb begin
    w_wr_val  = '0;
    w_wr_ctl  = '0;
    w_aux_nxt = '0;
    for (int c = 0; c < NumChannels; c++) begin
      w_wr_val[c]     = bus.bus_we_i && w_in_win && (w_ch == CW'(c)) && !w_sel_ctrl;
      w_wr_ctl[c]     = bus.bus_we_i && w_in_win && (w_ch == CW'(c)) && w_sel_ctrl;
      w_mode_nxt[c]   = w_wr_ctl[c] ? bus.bus_wdata_i[1:0] : r_mode[c];
      w_shadow_nxt[c] = (w_wr_ctl[c] || w_wrap) ? r_value[c] : r_shadow[c];
      w_pulse_nxt[c]  = r_pulse[c];
      if (w_wr_ctl[c]) begin
        w_pulse_nxt[c] = '0;
      end else if (w_wr_val[c] && (r_mode[c] == ModeOneshot)) begin
        w_pulse_nxt[c] = bus.bus_wdata_i;
      end else if (w_tick && (r_pulse[c] != '0)) begin
        w_pulse_nxt[c] = r_pulse[c] - DataWidth'(1);
      end
      case (w_mode_nxt[c])
        ModePwm:     w_aux_nxt[c] = (w_pwm_cnt_nxt < w_shadow_nxt[c]);
        ModeOneshot: w_aux_nxt[c] = (w_pulse_nxt[c] != '0);
        default:     w_aux_nxt[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_aux     <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        r_value[c]  <= '0;
        r_mode[c]   <= '0;
        r_shadow[c] <= '0;
        r_pulse[c]  <= '0;
      end
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_pwm_cnt <= w_pwm_cnt_nxt;
      r_aux     <= w_aux_nxt;
      for (int c = 0; c < NumChannels; c++) begin
        if (w_wr_val[c]) begin
          r_value[c] <= bus.bus_wdata_i;
        end
        r_mode[c]   <= w_mode_nxt[c];
        r_shadow[c] <= w_shadow_nxt[c];
        r_pulse[c]  <= w_pulse_nxt[c];
      end
    end
  end

  always_comb begin
    ex_data_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      ex_data_o[c*DataWidth +: DataWidth] = r_value[c];
    end
  end

  assign ex_aux_o = r_aux;

`ifdef EX_PORT_READBACK_EN
  logic [DataWidth-1:0] r_rdata;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rdata <= '0;
    end else if (w_in_win) begin
      r_rdata <= w_sel_ctrl ? DataWidth'(r_mode[w_ch]) : r_value[w_ch];
    end else begin
      r_rdata <= '0;
    end
  end

  assign bus.bus_rdata_o = r_rdata;
`else
  assign bus.bus_rdata_o = '0;
`endif

endmodule

// File: tb/tb_ex_port_bank.sv
// tb/tb_ex_port_bank.sv - randomized self-checking bench for ex_port_bank against a behavioural model
module tb_ex_port_bank;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int DIV = 3;
  localparam logic [AW-1:0] BASE = 16'h9100;
`ifdef EX_PORT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NC*DW-1:0] ex_data;
  logic [NC-1:0] ex_aux;

  ex_port_bank_if #(.AddressWidth(AW), .DataWidth(DW)) bus_if ();

  ex_port_bank #(
    .NumChannels(NC), .DataWidth(DW), .AddressWidth(AW),
    .BaseAddress(BASE), .PrescaleDiv(DIV)
  ) dut (
    .clk_i(clk), .reset_i(rst_n), .bus(bus_if),
    .ex_data_o(ex_data), .ex_aux_o(ex_aux)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: tick index from elapsed cycles, PWM counter = ticks mod 256.
  logic [DW-1:0] m_value [NC];
  logic [1:0] m_mode [NC];
  logic [DW-1:0] m_shadow [NC];
  int m_pulse [NC];
  longint m_cyc;
  longint m_ticks;
  logic [DW-1:0] m_rdata;
  logic [NC-1:0] m_aux;

  function automatic logic [AW-1:0] adr(input int off);
    return AW'(int'(BASE) + off);
  endfunction

  function automatic logic [NC*DW-1:0] m_data();
    logic [NC*DW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = m_value[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_value[c] = '0; m_mode[c] = '0; m_shadow[c] = '0; m_pulse[c] = 0;
    end
    m_cyc = 0; m_ticks = 0; m_rdata = '0; m_aux = '0;
  endtask

  task automatic model_edge();
    bit tick;
    int off;
    int ch;
    logic [NC-1:0] pset;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = ((m_cyc % DIV) == DIV - 1);
    off = int'(bus_if.bus_addr_i) - int'(BASE);
    ch = off / 2;
    m_rdata = '0;
    if (RB && off >= 0 && off < 2 * NC)
      m_rdata = (off % 2 == 1) ? DW'(m_mode[ch]) : m_value[ch];
    if (tick && (m_ticks % 256) == 255)
      for (int c = 0; c < NC; c++) m_shadow[c] = m_value[c];
    pset = '0;
    if (bus_if.bus_we_i && off >= 0 && off < 2 * NC) begin
      if (off % 2 == 1) begin
        m_mode[ch] = bus_if.bus_wdata_i[1:0];
        m_pulse[ch] = 0;
        m_shadow[ch] = m_value[ch];
        pset[ch] = 1'b1;
      end else begin
        if (m_mode[ch] == 2'b10) begin
          m_pulse[ch] = int'(bus_if.bus_wdata_i);
          pset[ch] = 1'b1;
        end
        m_value[ch] = bus_if.bus_wdata_i;
      end
    end
    if (tick) m_ticks++;
    m_cyc++;
    for (int c = 0; c < NC; c++) begin
      if (tick && !pset[c] && m_pulse[c] > 0) m_pulse[c]--;
      m_aux[c] = (m_mode[c] == 2'b01) ? ((m_ticks % 256) < longint'(m_shadow[c])) :
                 (m_mode[c] == 2'b10) ? (m_pulse[c] != 0) : 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [DW-1:0] d);
    bus_if.bus_addr_i = adr(off);
    bus_if.bus_wdata_i = d;
    bus_if.bus_we_i = 1'b1;
    cyc();
    bus_if.bus_we_i = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.bus_addr_i = BASE;
    bus_if.bus_wdata_i = '0;
    bus_if.bus_we_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_init got data=%h aux=%b rd=%h want all 0", ex_data, ex_aux, bus_if.bus_rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_write_readback();
    wr(2, 8'hA5);
    total++;
    if (ex_data[15:8] !== 8'hA5) begin
      bad++; $display("FAIL value1_data got %h want a5", ex_data[15:8]);
    end
    bus_if.bus_addr_i = adr(2);
    cyc();
    total++;
    if (bus_if.bus_rdata_o !== (RB ? 8'hA5 : 8'h00)) begin
      bad++; $display("FAIL value1_readback got %h want %h", bus_if.bus_rdata_o, RB ? 8'hA5 : 8'h00);
    end
    wr(3, 8'hFF);
    bus_if.bus_addr_i = adr(3);
    cyc();
    total++;
    if ({ex_aux[1], bus_if.bus_rdata_o} !== {1'b0, (RB ? 8'h03 : 8'h00)}) begin
      bad++; $display("FAIL ctrl1_readback got aux=%b rd=%h want aux=0 rd=%h", ex_aux[1], bus_if.bus_rdata_o, RB ? 8'h03 : 8'h00);
    end
    wr(3, 8'h00);
  endtask

  task automatic test_pwm();
    int hi;
    int n;
    wr(0, 8'd64);
    wr(1, 8'h01);
    hi = 0;
    for (int i = 0; i < 256 * DIV; i++) begin
      if (ex_aux[0]) hi++;
      cyc();
      total++;
      if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== {m_data(), m_aux, m_rdata}) begin
        bad++; $display("FAIL pwm64_trace t=%0t got %h/%b/%h want %h/%b/%h", $time, ex_data, ex_aux, bus_if.bus_rdata_o, m_data(), m_aux, m_rdata);
      end
    end
    total++;
    if (hi != 64 * DIV) begin bad++; $display("FAIL pwm64_duty got %0d want %0d", hi, 64 * DIV); end
    n = 0;
    while ((m_ticks % 256) != 128 && n < 2000) begin cyc(); n++; end
    wr(0, 8'd192);
    hi = 0;
    n = 0;
    while ((m_ticks % 256) != 0 && n < 2000) begin
      if (ex_aux[0]) hi++;
      cyc();
      n++;
      total++;
      if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== {m_data(), m_aux, m_rdata}) begin
        bad++; $display("FAIL pwm_mid_trace t=%0t got %h/%b/%h want %h/%b/%h", $time, ex_data, ex_aux, bus_if.bus_rdata_o, m_data(), m_aux, m_rdata);
      end
    end
    total++;
    if (hi != 0 || n >= 2000) begin bad++; $display("FAIL pwm_mid_keep got highs=%0d cycles=%0d want highs=0", hi, n); end
    hi = 0;
    for (int i = 0; i < 256 * DIV; i++) begin
      if (ex_aux[0]) hi++;
      cyc();
    end
    total++;
    if (hi != 192 * DIV) begin bad++; $display("FAIL pwm192_duty got %0d want %0d", hi, 192 * DIV); end
    wr(0, 8'd0);
    repeat (2 * DIV) cyc();
    n = 0;
    while ((m_ticks % 256) != 0 && n < 2000) begin cyc(); n++; end
    hi = 0;
    for (int i = 0; i < 256 * DIV; i++) begin
      if (ex_aux[0]) hi++;
      cyc();
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL pwm0_duty got %0d want 0", hi); end
    wr(1, 8'h00);
  endtask

  task automatic test_oneshot();
    int w;
    wr(5, 8'h02);
    repeat ($urandom_range(0, DIV - 1)) cyc();
    wr(4, 8'd5);
    w = 0;
    while (ex_aux[2] && w < 200) begin
      w++;
      cyc();
      total++;
      if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== {m_data(), m_aux, m_rdata}) begin
        bad++; $display("FAIL oneshot_trace t=%0t got %h/%b/%h want %h/%b/%h", $time, ex_data, ex_aux, bus_if.bus_rdata_o, m_data(), m_aux, m_rdata);
      end
    end
    total++;
    if (w < 4 * DIV + 1 || w > 5 * DIV) begin bad++; $display("FAIL oneshot5_width got %0d want %0d..%0d", w, 4 * DIV + 1, 5 * DIV); end
    wr(4, 8'd5);
    repeat (2) cyc();
    wr(4, 8'd3);
    w = 0;
    while (ex_aux[2] && w < 200) begin w++; cyc(); end
    total++;
    if (w < 2 * DIV + 1 || w > 3 * DIV) begin bad++; $display("FAIL oneshot3_restart got %0d want %0d..%0d", w, 2 * DIV + 1, 3 * DIV); end
    wr(4, 8'd5);
    cyc();
    wr(4, 8'd0);
    total++;
    if (ex_aux[2] !== 1'b0) begin bad++; $display("FAIL oneshot_abort got %b want 0", ex_aux[2]); end
    wr(4, 8'd9);
    wr(5, 8'h00);
    wr(5, 8'h02);
    total++;
    if (ex_aux[2] !== 1'b0) begin bad++; $display("FAIL oneshot_modeclear got %b want 0", ex_aux[2]); end
  endtask

  task automatic test_out_of_window();
    wr(2 * NC, 8'hFF);
    wr(-1, 8'hFF);
    bus_if.bus_addr_i = adr(2 * NC);
    cyc();
    total++;
    if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== {m_data(), m_aux, 8'h00}) begin
      bad++; $display("FAIL out_of_window got %h/%b/%h want %h/%b/00", ex_data, ex_aux, bus_if.bus_rdata_o, m_data(), m_aux);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus_if.bus_addr_i = adr(int'($urandom_range(0, 2 * NC + 3)) - 2);
      bus_if.bus_wdata_i = DW'($urandom);
      bus_if.bus_we_i = ($urandom_range(0, 3) == 0);
      cyc();
      total++;
      if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== {m_data(), m_aux, m_rdata}) begin
        bad++; $display("FAIL random_trace t=%0t got %h/%b/%h want %h/%b/%h", $time, ex_data, ex_aux, bus_if.bus_rdata_o, m_data(), m_aux, m_rdata);
      end
    end
    bus_if.bus_we_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr(0, 8'd128);
    wr(1, 8'h01);
    wr(7, 8'h02);
    wr(6, 8'd200);
    bus_if.bus_addr_i = adr(0);
    repeat (50) cyc();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== '0) begin
      bad++; $display("FAIL reset_mid got data=%h aux=%b rd=%h want all 0", ex_data, ex_aux, bus_if.bus_rdata_o);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 2 * NC; a++) begin
      bus_if.bus_addr_i = adr(a);
      cyc();
      total++;
      if ({ex_data, ex_aux, bus_if.bus_rdata_o} !== '0) begin
        bad++; $display("FAIL reset_regs off=%0d got %h/%b/%h want all 0", a, ex_data, ex_aux, bus_if.bus_rdata_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_pwm();
    test_oneshot();
    test_out_of_window();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
